// File: rtl/canny_pkg.sv
// Shared types and constants for the Canny edge-detection pipeline.
// Exports the pixel width, the signed gradient width, the direction codes
// and a helper that takes the magnitude of a signed gradient.
package canny_pkg;

  localparam int unsigned PIX_W  = 8;
  // Worst-case Sobel response is +/-4*255 = +/-1020, which needs 11 signed bits.
  localparam int unsigned GRAD_W = 11;

  localparam logic [1:0] DIR_0   = 2'd0;
  localparam logic [1:0] DIR_45  = 2'd1;
  localparam logic [1:0] DIR_90  = 2'd2;
  localparam logic [1:0] DIR_135 = 2'd3;

  // |g| for a signed gradient; never overflows because -1024 is unreachable.
  function automatic logic [GRAD_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
    logic [GRAD_W-1:0] mag;
    if (g[GRAD_W-1]) begin
      mag = GRAD_W'(-g);
    end else begin
      mag = GRAD_W'(g);
    end
    return mag;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Enable-gated WIDTH-deep pixel delay line.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointer only)
//   en         : advance the delay line by one pixel
//   din        : pixel entering the line
//   dout       : pixel that entered WIDTH enabled cycles ago
// Storage contents are deliberately not reset; only the pointer is.
module line_buffer #(
  parameter int unsigned WIDTH = 508,
  parameter int unsigned PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  localparam int unsigned AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [PIX_W-1:0] mem [WIDTH];
  logic [AW-1:0]    ptr_q;

  // Read-before-write at the same address gives exactly WIDTH cycles of delay.
  assign dout = mem[ptr_q];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (en) begin
      ptr_q <= (ptr_q == AW'(WIDTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/sobel_gradient.sv
// Streaming 3x3 Sobel gradient stage.
// Accepts a raster-order pixel stream, keeps two lines of history, and emits a
// saturated |Gx|+|Gy| magnitude plus a 2-bit quantised direction for every
// interior pixel, two cycles after the window-completing pixel is accepted.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   valid_in, pix_in  : input pixel stream (no backpressure)
//   valid_out         : mag_out / dir_out valid this cycle
//   mag_out           : min(|Gx|+|Gy|, 255)
//   dir_out           : 0=0deg, 1=45deg, 2=90deg, 3=135deg
//   frame_done        : pulse with the last valid_out of a frame
module sobel_gradient
  import canny_pkg::*;
#(
  parameter int unsigned WIDTH  = 508,
  parameter int unsigned HEIGHT = 508,
  // Gradient arithmetic is sized by GRAD_W, which assumes the package pixel width.
  parameter int unsigned PIX_W  = canny_pkg::PIX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [PIX_W-1:0] pix_in,
  output logic             valid_out,
  output logic [PIX_W-1:0] mag_out,
  output logic [1:0]       dir_out,
  output logic             frame_done
);

  localparam int unsigned CW = (WIDTH > 1)  ? $clog2(WIDTH)  : 1;
  localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned MW = GRAD_W + 2;  // holds 5*|G| for direction tests

  // ---------------------------------------------------------------------------
  // Raster position counters
  // ---------------------------------------------------------------------------
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          col_last, row_last;

  assign col_last = (col_q == CW'(WIDTH - 1));
  assign row_last = (row_q == RW'(HEIGHT - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (valid_in) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers and 3x3 window
  // ---------------------------------------------------------------------------
  logic [PIX_W-1:0] tap_mid;  // same column, previous line
  logic [PIX_W-1:0] tap_top;  // same column, two lines back

  line_buffer #(
    .WIDTH (WIDTH),
    .PIX_W (PIX_W)
  ) u_line_mid (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (valid_in),
    .din   (pix_in),
    .dout  (tap_mid)
  );

  line_buffer #(
    .WIDTH (WIDTH),
    .PIX_W (PIX_W)
  ) u_line_top (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (valid_in),
    .din   (tap_mid),
    .dout  (tap_top)
  );

  // w_q[r][c]: r=0 oldest line, c=2 newest column.
  logic [PIX_W-1:0] w_q [3][3];
  logic             win_valid_q, win_last_q;
  logic             win_ok;

  // Windows with col<2 straddle a line wrap; rows<2 still hold stale lines.
  assign win_ok = valid_in && (row_q >= RW'(2)) && (col_q >= CW'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          w_q[r][c] <= '0;
        end
      end
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      if (valid_in) begin
        for (int r = 0; r < 3; r++) begin
          w_q[r][0] <= w_q[r][1];
          w_q[r][1] <= w_q[r][2];
        end
        w_q[0][2] <= tap_top;
        w_q[1][2] <= tap_mid;
        w_q[2][2] <= pix_in;
      end
      win_valid_q <= win_ok;
      win_last_q  <= win_ok && row_last && col_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: Sobel kernels
  // ---------------------------------------------------------------------------
  logic [GRAD_W-1:0]        gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [GRAD_W-1:0] gx_d, gy_d, gx_q, gy_q;
  logic                     s1_valid_q, s1_last_q;

  always_comb begin
    gx_pos = GRAD_W'(w_q[0][2]) + (GRAD_W'(w_q[1][2]) << 1) + GRAD_W'(w_q[2][2]);
    gx_neg = GRAD_W'(w_q[0][0]) + (GRAD_W'(w_q[1][0]) << 1) + GRAD_W'(w_q[2][0]);
    gy_pos = GRAD_W'(w_q[2][0]) + (GRAD_W'(w_q[2][1]) << 1) + GRAD_W'(w_q[2][2]);
    gy_neg = GRAD_W'(w_q[0][0]) + (GRAD_W'(w_q[0][1]) << 1) + GRAD_W'(w_q[0][2]);
    gx_d   = signed'(gx_pos - gx_neg);
    gy_d   = signed'(gy_pos - gy_neg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_q       <= '0;
      gy_q       <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else begin
      if (win_valid_q) begin
        gx_q <= gx_d;
        gy_q <= gy_d;
      end
      s1_valid_q <= win_valid_q;
      s1_last_q  <= win_valid_q && win_last_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: magnitude and direction
  // ---------------------------------------------------------------------------
  logic [GRAD_W-1:0] abs_x, abs_y, abs_sum;
  logic [MW-1:0]     ax2, ax5, by2, by5;
  logic [PIX_W-1:0]  mag_d;
  logic [1:0]        dir_d;

  always_comb begin
    abs_x   = abs_grad(gx_q);
    abs_y   = abs_grad(gy_q);
    abs_sum = abs_x + abs_y;
    mag_d   = (abs_sum > GRAD_W'({PIX_W{1'b1}})) ? {PIX_W{1'b1}} : abs_sum[PIX_W-1:0];

    ax2 = MW'(abs_x) << 1;
    ax5 = (MW'(abs_x) << 2) + MW'(abs_x);
    by2 = MW'(abs_y) << 1;
    by5 = (MW'(abs_y) << 2) + MW'(abs_y);

    // tan(22.5deg) ~ 2/5 and tan(67.5deg) ~ 5/2; a zero gradient lands in DIR_0.
    if (by5 <= ax2) begin
      dir_d = DIR_0;
    end else if (by2 >= ax5) begin
      dir_d = DIR_90;
    end else if (gx_q[GRAD_W-1] == gy_q[GRAD_W-1]) begin
      dir_d = DIR_45;
    end else begin
      dir_d = DIR_135;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out  <= 1'b0;
      mag_out    <= '0;
      dir_out    <= DIR_0;
      frame_done <= 1'b0;
    end else begin
      if (s1_valid_q) begin
        mag_out <= mag_d;
        dir_out <= dir_d;
      end
      valid_out  <= s1_valid_q;
      frame_done <= s1_valid_q && s1_last_q;
    end
  end

endmodule

// File: tb/tb_sobel_gradient.sv
// Self-checking bench for sobel_gradient on an 8x6 frame: fixed test images,
// randomised idle gaps and random images, compared against a per-pixel Sobel
// model evaluated directly on the stored input image.
module tb_sobel_gradient;

  localparam int W = 8;
  localparam int H = 6;
  localparam int OUTS = (W - 2) * (H - 2);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_in;
  logic [7:0] pix_in;
  logic       valid_out;
  logic [7:0] mag_out;
  logic [1:0] dir_out;
  logic       frame_done;

  sobel_gradient #(
    .WIDTH  (W),
    .HEIGHT (H),
    .PIX_W  (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .pix_in     (pix_in),
    .valid_out  (valid_out),
    .mag_out    (mag_out),
    .dir_out    (dir_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     mag;
    int     dir;
    int     last;
    longint at;
  } exp_t;

  exp_t exp_q[$];
  int   img [H][W];
  int   total = 0;
  int   bad   = 0;
  int   n_out = 0;
  int   n_fd  = 0;
  bit   running = 1'b0;

  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Expected result for the window whose bottom-right pixel is (r, c).
  function automatic exp_t model(input int r, input int c);
    exp_t e;
    int gx, gy, a, b;
    gx = (img[r-2][c] + 2 * img[r-1][c] + img[r][c])
       - (img[r-2][c-2] + 2 * img[r-1][c-2] + img[r][c-2]);
    gy = (img[r][c-2] + 2 * img[r][c-1] + img[r][c])
       - (img[r-2][c-2] + 2 * img[r-2][c-1] + img[r-2][c]);
    a = iabs(gx);
    b = iabs(gy);
    e.mag = (a + b > 255) ? 255 : a + b;
    if (5 * b <= 2 * a) e.dir = 0;
    else if (2 * b >= 5 * a) e.dir = 2;
    else if ((gx < 0) == (gy < 0)) e.dir = 1;
    else e.dir = 3;
    e.last = (r == H - 1 && c == W - 1) ? 1 : 0;
    e.at   = 0;
    return e;
  endfunction

  function automatic int pattern(input int kind, input int r, input int c);
    case (kind)
      0:       return 8'h80;
      1:       return (c < 4) ? 8'h00 : 8'hFF;
      2:       return 10 * r;
      3:       return 4 * (r + c);
      4:       return 100 + 4 * c - 4 * r;
      default: return int'($urandom_range(255, 0));
    endcase
  endfunction

  // Drive n_pix pixels of a frame with 0..max_gap idle cycles before each one.
  task automatic send_frame(input int kind, input int max_gap, input int n_pix);
    exp_t e;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = pattern(kind, r, c);
    for (int i = 0; i < n_pix; i++) begin
      int r, c, gap;
      r = i / W;
      c = i % W;
      gap = int'($urandom_range(max_gap, 0));
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      valid_in = 1'b1;
      pix_in   = 8'(img[r][c]);
      @(posedge clk);
      #1;
      if (r >= 2 && c >= 2) begin
        e    = model(r, c);
        e.at = cyc + 2;
        exp_q.push_back(e);
      end
      valid_in = 1'b0;
    end
  endtask

  task automatic drain(input int frames);
    repeat (4) @(posedge clk);
    #1;
    check("pending", exp_q.size(), 0);
    check("n_out", n_out, OUTS * frames);
    check("n_frame_done", n_fd, frames);
    n_out = 0;
    n_fd  = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_valid_out", int'(valid_out), 0);
    check("rst_mag_out", int'(mag_out), 0);
    check("rst_dir_out", int'(dir_out), 0);
    check("rst_frame_done", int'(frame_done), 0);
  endtask

  always @(negedge clk) begin
    if (running && rst_n) begin
      if (valid_out) begin
        exp_t e;
        n_out++;
        if (frame_done) n_fd++;
        if (exp_q.size() == 0) begin
          check("unexpected_valid_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("mag", int'(mag_out), e.mag);
          check("dir", int'(dir_out), e.dir);
          check("frame_done", int'(frame_done), e.last);
          check("latency_cycle", int'(cyc), int'(e.at));
        end
      end else begin
        check("frame_done_idle", int'(frame_done), 0);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    pix_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n   = 1'b1;
    running = 1'b1;

    send_frame(0, 0, W * H);  // flat
    drain(1);
    send_frame(1, 0, W * H);  // vertical step, saturates
    drain(1);
    send_frame(2, 0, W * H);  // vertical ramp
    drain(1);
    send_frame(3, 0, W * H);  // 45 deg diagonal
    drain(1);
    send_frame(4, 0, W * H);  // 135 deg diagonal
    drain(1);
    send_frame(2, 3, W * H);  // ramp with random gaps
    drain(1);
    for (int k = 0; k < 3; k++) begin
      send_frame(5, 2, W * H);  // random image, random gaps
    end
    drain(3);

    // Reset mid-frame: in-flight windows must be discarded.
    send_frame(5, 0, 20);
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    check("partial_frame_out", n_out, 0);
    n_out = 0;
    n_fd  = 0;
    rst_n = 1'b1;
    send_frame(0, 0, W * H);
    send_frame(2, 0, W * H);  // back-to-back with the flat frame
    drain(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
